// File: rtl/fp_norm_round.sv
// Normalise / round-to-nearest-even / pack stage behind the FP multiplier.
// Three register stages (LZC, shift, round+pack) share one advance enable.
module fp_norm_round #(
  parameter int MW   = 28,
  parameter int EW   = 8,
  parameter int FW   = 23,
  parameter int BIAS = 127
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sign,
  input  logic [EW-1:0]       exp,
  input  logic [MW-1:0]       mantis,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1+EW+FW-1:0]  result,
  output logic                overflow,
  output logic                underflow
);

  localparam int LW = $clog2(MW + 1);
  localparam int XW = EW + 2;
  localparam int RW = 1 + EW + FW;
  localparam int GB = MW - 2 - FW;
  localparam logic signed [XW-1:0] EXP_INF = XW'(2 * BIAS + 1);

  logic en;

  logic          s1_vld_q;
  logic          s1_sign_q;
  logic [EW-1:0] s1_exp_q;
  logic [MW-1:0] s1_mant_q;
  logic [LW-1:0] s1_lzc_q;
  logic          s1_inf_q;
  logic [LW-1:0] lzc_d;

  logic                 s2_vld_q;
  logic                 s2_sign_q;
  logic [MW-2:0]        s2_mn_q;
  logic signed [XW-1:0] s2_eadj_q;
  logic                 s2_zero_q;
  logic                 s2_inf_q;
  logic [MW-1:0]        mn_d;
  logic signed [XW-1:0] eadj_d;

  logic [FW-1:0]        frac;
  logic                 guard_bit;
  logic                 sticky_bit;
  logic                 rnd_up;
  logic [FW:0]          frac_r;
  logic signed [XW-1:0] e_fin;
  logic [RW-1:0]        res_d;
  logic                 ovf_d;
  logic                 unf_d;

  logic          out_valid_q;
  logic [RW-1:0] result_q;
  logic          ovf_q;
  logic          unf_q;

  // Whole pipe moves together; a stalled output freezes every stage, bubbles included.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // NOTE: the default before the loop makes every path assign lzc_d, so no latch is inferred.
  always_comb begin
    lzc_d = LW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (mantis[i]) lzc_d = LW'(MW - 1 - i);
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
  // Data registers are reset as well, so result reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_mant_q <= '0;
      s1_lzc_q  <= '0;
      s1_inf_q  <= 1'b0;
    end else if (en) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= sign;
        s1_exp_q  <= exp;
        s1_mant_q <= mantis;
        s1_lzc_q  <= lzc_d;
        s1_inf_q  <= (&exp) & (|mantis);
      end
    end
  end

  // Normalised mantissa MSB is the hidden one; its absence means the input was zero.
  assign mn_d   = s1_mant_q << s1_lzc_q;
  assign eadj_d = signed'({2'b00, s1_exp_q}) - signed'({{(XW - LW){1'b0}}, s1_lzc_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_mn_q   <= '0;
      s2_eadj_q <= '0;
      s2_zero_q <= 1'b0;
      s2_inf_q  <= 1'b0;
    end else if (en) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_sign_q <= s1_sign_q;
        s2_mn_q   <= mn_d[MW-2:0];
        s2_eadj_q <= eadj_d;
        s2_zero_q <= ~mn_d[MW-1];
        s2_inf_q  <= s1_inf_q;
      end
    end
  end

  assign frac       = s2_mn_q[MW-2 -: FW];
  assign guard_bit  = s2_mn_q[GB];
  assign sticky_bit = |s2_mn_q[GB-1:0];
  assign rnd_up     = guard_bit & (sticky_bit | frac[0]);
  assign frac_r     = {1'b0, frac} + (FW + 1)'(rnd_up);
  assign e_fin      = s2_eadj_q + XW'(frac_r[FW]);

  // A carry out of the fraction leaves frac_r[FW-1:0] at zero, exactly as required.
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_zero_q) begin
      res_d = {s2_sign_q, {(RW - 1){1'b0}}};
    end else if (e_fin <= 0) begin
      res_d = {s2_sign_q, {(RW - 1){1'b0}}};
      unf_d = 1'b1;
    end else if (e_fin >= EXP_INF || s2_inf_q) begin
      res_d = {s2_sign_q, {EW{1'b1}}, {FW{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      res_d = {s2_sign_q, e_fin[EW-1:0], frac_r[FW-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= s2_vld_q;
      if (s2_vld_q) begin
        result_q <= res_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = out_valid_q & ovf_q;
  assign underflow = out_valid_q & unf_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: driver pushes hand-computed expectations,
// an independent monitor pops and compares every consumed output.
module tb_fp_norm_round;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  typedef struct packed {
    logic        sgn;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [7:0]  exp;
  logic [27:0] mantis;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  fp_norm_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .exp       (exp),
    .mantis    (mantis),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Called just after a negedge; returns on the negedge following acceptance.
  task automatic send(input logic sg, input logic [7:0] e, input logic [27:0] m,
                      input logic [31:0] res, input logic ovf, input logic unf);
    int n = 0;
    exp_t x;
    in_valid = 1'b1;
    sign     = sg;
    exp      = e;
    mantis   = m;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
    x.res = res;
    x.ovf = ovf;
    x.unf = unf;
    sb_q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: compares consumed outputs and checks stability while stalled.
  logic [31:0] held_res;
  logic        held_vld = 1'b0;
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        held_vld = 1'b0;
      end else if (out_valid && out_ready) begin
        held_vld = 1'b0;
        if (sb_q.size() == 0) begin
          check("unexpected_output", {31'b0, out_valid}, 32'd0);
        end else begin
          x = sb_q.pop_front();
          check("result", result, x.res);
          check("overflow", {31'b0, overflow}, {31'b0, x.ovf});
          check("underflow", {31'b0, underflow}, {31'b0, x.unf});
        end
      end else if (out_valid && !out_ready) begin
        check("in_ready_stall", {31'b0, in_ready}, 32'd0);
        if (held_vld) check("stall_stable", result, held_res);
        held_res = result;
        held_vld = 1'b1;
      end else begin
        held_vld = 1'b0;
      end
    end
  end

  vec_t vecs[12];

  initial begin
    int n;
    int seen;

    vecs[0]  = '{1'b0, 8'd127, 28'h8000000, 32'h3F800000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd127, 28'h4000000, 32'h3F000000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'd100, 28'h0000001, 32'h24800000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'd127, 28'h8000008, 32'h3F800000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'd127, 28'h8000018, 32'h3F800002, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'd127, 28'hFFFFFF8, 32'h40000000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'd254, 28'hFFFFFF8, 32'h7F800000, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'd1,   28'h4000000, 32'h80000000, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'd50,  28'h0000000, 32'h80000000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'd255, 28'h0000001, 32'h7F800000, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'd127, 28'h8000009, 32'h3F800001, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'd0,   28'h8000000, 32'h00000000, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sign      = 1'b0;
    exp       = '0;
    mantis    = '0;
    out_ready = 1'b1;
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", {30'b0, overflow, underflow}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First vector alone to measure accept-to-valid latency.
    send(vecs[0].sgn, vecs[0].e, vecs[0].m, vecs[0].res, vecs[0].ovf, vecs[0].unf);
    #1;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("latency", n, 32'd2);
    @(negedge clk);

    for (int i = 1; i < 12; i++)
      send(vecs[i].sgn, vecs[i].e, vecs[i].m, vecs[i].res, vecs[i].ovf, vecs[i].unf);

    // Backpressure: six back-to-back inputs while the sink refuses for five cycles.
    out_ready = 1'b0;
    fork
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 6; i++)
      send(1'b0, 8'(120 + i), 28'h8000000, {1'b0, 8'(120 + i), 23'b0}, 1'b0, 1'b0);

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_before_reset", sb_q.size(), 32'd0);

    // Reset with three items in flight; nothing stale may follow release.
    out_ready = 1'b1;
    send(1'b0, 8'd127, 28'h8000000, 32'h3F800000, 1'b0, 1'b0);
    send(1'b1, 8'd254, 28'hFFFFFF8, 32'hFF800000, 1'b1, 1'b0);
    send(1'b1, 8'd1,   28'h4000000, 32'h80000000, 1'b0, 1'b1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {30'b0, overflow, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no_stale_after_reset", seen, 32'd0);

    // Pipeline still usable after reset.
    @(negedge clk);
    send(1'b1, 8'd128, 28'h4000000, 32'hBF800000, 1'b0, 1'b0);
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("final_drain", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Downstream stage of the floating-point multiplier.
- Consumes the raw {sign, biased exponent, 28-bit mantissa} result and normalises it.
- Rounds to nearest-even and packs into an IEEE-754 single-precision word.
- 3-stage pipeline with valid/ready handshake; raises overflow/underflow flags.

Parameters:
- MW, 28, input mantissa width (hidden-one position at bit MW-1)
- EW, 8, exponent width
- FW, 23, packed fraction width
- BIAS, 127, exponent bias

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input triple valid
- in_ready  output  1  block accepts input this cycle
- sign  input  1  result sign
- exp  input  8  biased exponent
- mantis  input  28  mantissa; value = mantis[27].mantis[26:0], may have leading zeros
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  32  packed IEEE single {sign, exp[7:0], frac[22:0]}
- overflow  output  1  result saturated to infinity (qualified by out_valid)
- underflow  output  1  nonzero result flushed to zero (qualified by out_valid)

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits clear; out_valid=0, result=0, overflow=0, underflow=0.
  - Reset mid-operation discards in-flight data; no output follows deassertion until new input.
- Handshake:
  - Global advance en = ~out_valid | out_ready; in_ready = en.
  - Transfer on in_valid & in_ready; output consumed on out_valid & out_ready.
  - When en=0 every stage holds; results are never dropped or duplicated and order is preserved.
  - Bubbles are not collapsed.
  - Latency: 3 cycles from accept to out_valid with no stall.
  - Throughput: 1 result per cycle.
- S1: register sign/exp/mantis; compute lzc = leading-zero count of mantis (0..28; 28 means zero).
- S2:
  - m_n = mantis << lzc (28 bit).
  - e_adj = {2'b00,exp} - lzc as 10-bit signed.
  - zero flag = (lzc==28).
- S3 round/pack:
  - frac = m_n[26:4], G = m_n[3], S = |m_n[2:0].
  - Round up when G & (S | frac[0]), i.e. ties to even.
  - If the round-up carries out of frac: frac=0 and e_adj+1.
- Exceptions in S3, priority order:
  - zero → {sign,31'b0}, no flags.
  - e_final <= 0 → {sign,31'b0}, underflow=1 (flush, no denormals).
  - e_final >= 255 → {sign,8'hFF,23'b0}, overflow=1. exp=255 input with nonzero mantis also gives infinity; NaN is not produced.
  - Otherwise → {sign, e_final[7:0], frac}.
- Flags are registered with result and valid only with out_valid; they are 0 on non-exceptional results.
- Negative zero is preserved (sign passes through unchanged).

Test Plan:
- sign=0, exp=127, mantis=28'h8000000, out_ready=1 → 3 cycles later result=32'h3F800000, flags 0.
- Normalisation:
  - exp=127, mantis=28'h4000000 → result=32'h3F000000.
  - mantis=28'h0000001 → lzc=27, exp 100 becomes 73 → 32'h24800000.
- Tie handling:
  - mantis=28'h8000008, exp=127 → 32'h3F800000 (tie, even, no round-up).
  - mantis=28'h8000018 → 32'h3F800002.
  - mantis=28'hFFFFFF8 → carry to 32'h40000000.
- Exceptions:
  - exp=254, mantis=28'hFFFFFF8 → 32'h7F800000, overflow=1.
  - sign=1, exp=1, mantis=28'h4000000 → 32'h80000000, underflow=1.
  - mantis=0 → signed zero, no flags.
- Backpressure:
  - 6 back-to-back inputs, out_ready=0 for 5 cycles → in_ready falls once out_valid=1; all 6 results emerge in order, none lost or repeated.
  - out_valid/result remain stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 items in flight → out_valid drops immediately, flags and result read 0; after release, no stale output appears.
